pc_stack_seq: RTL and testbench

//  Parametrised program counter with call/return stack; successor to the 4-bit PC.

---
 rtl/pc_stack_seq.sv | 133 +++++++++++++
 tb/tb_pc_stack_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_stack_seq.sv
// Fetch-stage program counter with a hardware call/return stack.
// out is the instruction-memory address; stkErr latches any overflow/underflow attempt.
module pc_stack_seq #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STEP      = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_VEC = 0,
    localparam int unsigned SPW      = $clog2(DEPTH + 1),
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] loadIn,
    output logic [WIDTH-1:0] out,
    output logic [SPW-1:0]   sp,
    output logic             stkFull,
    output logic             stkEmpty,
    output logic             stkErr
);

    typedef enum logic [2:0] {
        OP_HOLD    = 3'b000,
        OP_LOAD    = 3'b001,
        OP_INC     = 3'b010,
        OP_STEP    = 3'b011,
        OP_BRANCH  = 3'b100,
        OP_CALL    = 3'b101,
        OP_RETURN  = 3'b110,
        OP_RESTART = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [SPW-1:0]   DEPTH_W  = SPW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             push_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             full_s;
    logic             empty_s;
    op_e              op_s;

    assign op_s       = op_e'(cntrl);
    assign full_s     = (sp_q == DEPTH_W);
    assign empty_s    = (sp_q == {SPW{1'b0}});
    assign ret_addr_s = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign wr_idx_s   = AW'(sp_q);
    assign rd_idx_s   = AW'(sp_q - {{(SPW-1){1'b0}}, 1'b1});

    // Next-state decode for PC, stack pointer, error flag and push strobe
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        err_d  = err_q;
        push_s = 1'b0;
        if (en) begin
            case (op_s)
                OP_HOLD:   pc_d = pc_q;
                OP_LOAD:   pc_d = loadIn;
                OP_INC:    pc_d = ret_addr_s;
                OP_STEP:   pc_d = pc_q + STEP_W;
                // Equal widths: a plain modular add is the sign-extended relative branch.
                OP_BRANCH: pc_d = pc_q + loadIn;
                OP_CALL: begin
                    if (!full_s) begin
                        push_s = 1'b1;
                        sp_d   = sp_q + {{(SPW-1){1'b0}}, 1'b1};
                        pc_d   = loadIn;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
                OP_RETURN: begin
                    if (!empty_s) begin
                        pc_d = stack_q[rd_idx_s];
                        sp_d = sp_q - {{(SPW-1){1'b0}}, 1'b1};
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RESTART: begin
                    pc_d  = RESET_PC;
                    sp_d  = {SPW{1'b0}};
                    err_d = 1'b0;
                end
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PC, stack pointer and sticky error registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q  <= RESET_PC;
            sp_q  <= {SPW{1'b0}};
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage, written only on a successful call
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            stack_q[wr_idx_s] <= ret_addr_s;
        end else begin
            stack_q <= stack_q;
        end
    end

    assign out      = pc_q;
    assign sp       = sp_q;
    assign stkErr   = err_q;
    assign stkFull  = full_s;
    assign stkEmpty = empty_s;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed self-checking bench for pc_stack_seq at WIDTH=4, STEP=2, DEPTH=4, RESET_VEC=0.
module tb_pc_stack_seq;

    logic       clk;
    logic       clr;
    logic       en;
    logic [2:0] cntrl;
    logic [3:0] loadIn;
    logic [3:0] out;
    logic [2:0] sp;
    logic       stkFull;
    logic       stkEmpty;
    logic       stkErr;

    int checks_total;
    int checks_passed;

    pc_stack_seq #(
        .WIDTH(4), .STEP(2), .DEPTH(4), .RESET_VEC(0)
    ) dut (
        .clk(clk), .clr(clr), .en(en), .cntrl(cntrl), .loadIn(loadIn),
        .out(out), .sp(sp), .stkFull(stkFull), .stkEmpty(stkEmpty), .stkErr(stkErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one op across a rising edge, leaving the bench 1 time unit past it.
    task automatic op(input logic [2:0] c, input logic [3:0] ld);
        cntrl  = c;
        loadIn = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_out,
                               input logic [2:0] e_sp, input logic e_err);
        check({tag, ".out"}, 32'(out), 32'(e_out));
        check({tag, ".sp"},  32'(sp),  32'(e_sp));
        check({tag, ".err"}, 32'(stkErr), 32'(e_err));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        clr    = 1'b0;
        en     = 1'b1;
        cntrl  = 3'b000;
        loadIn = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 4'h0, 3'd0, 1'b0);
        check("reset.empty", 32'(stkEmpty), 32'd1);
        check("reset.full",  32'(stkFull),  32'd0);
        clr = 1'b1;

        // T1 increment / step / wrap
        op(3'b010, 4'h0); check("t1.inc1", 32'(out), 32'h1);
        op(3'b010, 4'h0); check("t1.inc2", 32'(out), 32'h2);
        op(3'b010, 4'h0); check("t1.inc3", 32'(out), 32'h3);
        op(3'b011, 4'h0); check("t1.step1", 32'(out), 32'h5);
        op(3'b011, 4'h0); check("t1.step2", 32'(out), 32'h7);
        op(3'b000, 4'h9); check("t1.hold", 32'(out), 32'h7);
        op(3'b001, 4'hE); check("t1.load", 32'(out), 32'hE);
        op(3'b011, 4'h0); check("t1.stepwrap", 32'(out), 32'h0);

        // T2 relative branch, backward and wrapping forward
        op(3'b001, 4'h3);
        op(3'b100, 4'hE); check("t2.back", 32'(out), 32'h1);
        op(3'b001, 4'hA);
        op(3'b100, 4'h7); check("t2.wrap", 32'(out), 32'h1);

        // T3 nested call / return
        op(3'b001, 4'h2);
        op(3'b101, 4'h8); check_state("t3.call1", 4'h8, 3'd1, 1'b0);
        op(3'b101, 4'hC); check_state("t3.call2", 4'hC, 3'd2, 1'b0);
        op(3'b110, 4'h0); check_state("t3.ret1", 4'h9, 3'd1, 1'b0);
        op(3'b110, 4'h0); check_state("t3.ret2", 4'h3, 3'd0, 1'b0);

        // T4 fill stack, overflow, pop; out=3 here
        op(3'b101, 4'h8); check("t4.c1", 32'(out), 32'h8);
        op(3'b101, 4'h6); check("t4.c2", 32'(out), 32'h6);
        op(3'b101, 4'h2); check("t4.c3full", 32'(stkFull), 32'd0);
        op(3'b101, 4'h9); check_state("t4.c4", 4'h9, 3'd4, 1'b0);
        check("t4.full", 32'(stkFull), 32'd1);
        op(3'b101, 4'hF); check_state("t4.ovf", 4'h9, 3'd4, 1'b1);
        op(3'b110, 4'h0); check_state("t4.pop", 4'h3, 3'd3, 1'b1);
        check("t4.notfull", 32'(stkFull), 32'd0);
        op(3'b001, 4'hF);
        op(3'b101, 4'h5); check_state("t4.callF", 4'h5, 3'd4, 1'b1);
        op(3'b110, 4'h0); check("t4.retwrap", 32'(out), 32'h0);
        op(3'b110, 4'h0); check("t4.pop3", 32'(out), 32'h7);
        op(3'b110, 4'h0); check("t4.pop2", 32'(out), 32'h9);
        op(3'b110, 4'h0); check_state("t4.pop1", 4'h4, 3'd0, 1'b1);

        // T5 underflow then restart
        op(3'b111, 4'h0); check_state("t5.rst1", 4'h0, 3'd0, 1'b0);
        op(3'b001, 4'h6);
        op(3'b110, 4'h0); check_state("t5.unf", 4'h6, 3'd0, 1'b1);
        check("t5.empty", 32'(stkEmpty), 32'd1);
        op(3'b111, 4'h0); check_state("t5.rst2", 4'h0, 3'd0, 1'b0);

        // T6 stall, then async reset mid-call
        op(3'b001, 4'h5);
        op(3'b101, 4'h8); check_state("t6.call", 4'h8, 3'd1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(3'b101, 4'hC);
            check_state("t6.stall", 4'h8, 3'd1, 1'b0);
        end
        op(3'b111, 4'h0); check_state("t6.stallrst", 4'h8, 3'd1, 1'b0);
        en     = 1'b1;
        cntrl  = 3'b101;
        loadIn = 4'hC;
        #2;
        clr = 1'b0;
        #1;
        check_state("t6.clr", 4'h0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check_state("t6.clrhold", 4'h0, 3'd0, 1'b0);
        clr = 1'b1;
        op(3'b110, 4'h0); check_state("t6.lost", 4'h0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
